// File: rtl/predelay_commutator.sv
// -----------------------------------------------------------------------------
// predelay_commutator
//   Front half of one R2MDC stage. It sits between a butterfly's two outputs
//   and the postdelay commutator. Butterfly path 1 goes through a circular
//   delay line of DELAY_CYCLES valid samples. A two-way switch then either
//   passes both paths straight or crosses them. The switch changes state
//   every DELAY_CYCLES outputs. The block also produces the output pair index
//   that the postdelay commutator consumes.
//
//   Optional feature: define PREDELAY_DRAIN_EN to add the `drain` input.
//   While in_valid=0 and the delay line is primed, drain=1 advances the block
//   as if zero samples were presented on both paths. This flushes the last
//   DELAY_CYCLES delayed samples out of the block.
//
// Ports
//   CLK                    in   1   clock, posedge
//   RST                    in   1   synchronous active-high reset
//   drain                  in   1   flush request (PREDELAY_DRAIN_EN only)
//   in_valid               in   1   bf_out* hold a valid sample pair
//   bf_out0_re/_im         in   16  butterfly path 0 (undelayed)
//   bf_out1_re/_im         in   16  butterfly path 1 (delayed by D)
//   cm_out0_re/_im         out  16  commutator output 0, registered
//   cm_out1_re/_im         out  16  commutator output 1, registered
//   out_valid              out  1   cm_out* valid this cycle
//   cntr_IFFT_input_pairs  out  5   output pair index mod NUM_INPUTS_PER_PATH
// -----------------------------------------------------------------------------
module predelay_commutator #(
  parameter int DELAY_CYCLES        = 16,
  parameter int NUM_INPUTS_PER_PATH = 32
) (
  input  logic                                   CLK,
  input  logic                                   RST,
`ifdef PREDELAY_DRAIN_EN
  input  logic                                   drain,
`endif
  input  logic                                   in_valid,
  input  logic [15:0]                            bf_out0_re,
  input  logic [15:0]                            bf_out0_im,
  input  logic [15:0]                            bf_out1_re,
  input  logic [15:0]                            bf_out1_im,
  output logic [15:0]                            cm_out0_re,
  output logic [15:0]                            cm_out0_im,
  output logic [15:0]                            cm_out1_re,
  output logic [15:0]                            cm_out1_im,
  output logic                                   out_valid,
  output logic [$clog2(NUM_INPUTS_PER_PATH)-1:0] cntr_IFFT_input_pairs
);

  localparam int AW = $clog2(DELAY_CYCLES);
  localparam int CW = $clog2(NUM_INPUTS_PER_PATH);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DELAY_CYCLES);
  localparam logic [AW-1:0] SW_LAST   = AW'(DELAY_CYCLES - 1);

  // Delay RAM is deliberately left uninitialised; only primed entries are read.
  logic [31:0]   mem_r [DELAY_CYCLES];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] sw_cnt_r;
  logic [AW:0]   fill_r;
  logic          sw_r;
  logic [CW-1:0] pair_idx_r;

  logic [31:0]   cm_out0_r;
  logic [31:0]   cm_out1_r;
  logic          out_valid_r;
  logic [CW-1:0] cntr_r;

  logic          primed_s;
  logic          advance_s;
  logic [31:0]   path0_s;
  logic [31:0]   path1_s;
  logic [31:0]   delayed_s;

  assign primed_s  = (fill_r == FILL_FULL);
  // Read-before-write: this slot still holds the path-1 sample from D steps ago.
  assign delayed_s = mem_r[wr_ptr_r];

  // Select what advances the block and which samples it consumes.
  always_comb begin
    advance_s = 1'b0;
    path0_s   = 32'h0000_0000;
    path1_s   = 32'h0000_0000;
`ifdef PREDELAY_DRAIN_EN
    // A real input always wins over drain; drain is ignored until primed.
    if (in_valid) begin
      advance_s = 1'b1;
      path0_s   = {bf_out0_re, bf_out0_im};
      path1_s   = {bf_out1_re, bf_out1_im};
    end else begin
      advance_s = drain & primed_s;
      path0_s   = 32'h0000_0000;
      path1_s   = 32'h0000_0000;
    end
`else
    advance_s = in_valid;
    path0_s   = {bf_out0_re, bf_out0_im};
    path1_s   = {bf_out1_re, bf_out1_im};
`endif
  end

  // Delay line storage: write the incoming path-1 sample into the slot just read.
  always_ff @(posedge CLK) begin
    if (!RST && advance_s) begin
      mem_r[wr_ptr_r] <= path1_s;
    end
  end

  // Control state, switch and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r    <= '0;
      sw_cnt_r    <= '0;
      fill_r      <= '0;
      sw_r        <= 1'b0;
      pair_idx_r  <= '0;
      cm_out0_r   <= 32'h0000_0000;
      cm_out1_r   <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      cntr_r      <= '0;
    end else if (advance_s) begin
      wr_ptr_r <= wr_ptr_r + AW'(1);
      if (!primed_s) begin
        // Still priming: the delayed path holds nothing useful yet.
        fill_r      <= fill_r + (AW+1)'(1);
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b1;
        cm_out0_r   <= sw_r ? delayed_s : path0_s;
        cm_out1_r   <= sw_r ? path0_s   : delayed_s;
        cntr_r      <= pair_idx_r;
        pair_idx_r  <= pair_idx_r + CW'(1);
        // D is a power of two, so the counter wraps on its own.
        sw_cnt_r    <= sw_cnt_r + AW'(1);
        if (sw_cnt_r == SW_LAST) begin
          sw_r <= ~sw_r;
        end
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign cm_out0_re            = cm_out0_r[31:16];
  assign cm_out0_im            = cm_out0_r[15:0];
  assign cm_out1_re            = cm_out1_r[31:16];
  assign cm_out1_im            = cm_out1_r[15:0];
  assign out_valid             = out_valid_r;
  assign cntr_IFFT_input_pairs = cntr_r;

endmodule

// File: tb/tb_predelay_commutator.sv
// -----------------------------------------------------------------------------
// tb_predelay_commutator
//   Drives two instances (D=4 and D=16) with the same stimulus and compares
//   both against a sample-history reference model: output j pairs path-0
//   sample j+D with path-1 sample j, crossed when (j/D) is odd, and carries
//   index j mod 32.
// -----------------------------------------------------------------------------
module tb_predelay_commutator;

`ifdef PREDELAY_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        drain = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] bf_out0_re = 16'h0, bf_out0_im = 16'h0;
  logic [15:0] bf_out1_re = 16'h0, bf_out1_im = 16'h0;

  logic [15:0] c0re4, c0im4, c1re4, c1im4;
  logic [15:0] c0re16, c0im16, c1re16, c1im16;
  logic        ov4, ov16;
  logic [4:0]  cn4, cn16;

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance (0: D=4, 1: D=16)
  int          cnt [2];
  logic [31:0] hist [2][4096];
  logic [31:0] e0 [2];
  logic [31:0] e1 [2];
  logic [4:0]  ec [2];
  logic        ev [2];

  always #5 CLK = ~CLK;

  predelay_commutator #(.DELAY_CYCLES(4), .NUM_INPUTS_PER_PATH(32)) dut4 (
    .CLK(CLK), .RST(RST),
`ifdef PREDELAY_DRAIN_EN
    .drain(drain),
`endif
    .in_valid(in_valid),
    .bf_out0_re(bf_out0_re), .bf_out0_im(bf_out0_im),
    .bf_out1_re(bf_out1_re), .bf_out1_im(bf_out1_im),
    .cm_out0_re(c0re4), .cm_out0_im(c0im4),
    .cm_out1_re(c1re4), .cm_out1_im(c1im4),
    .out_valid(ov4), .cntr_IFFT_input_pairs(cn4)
  );

  predelay_commutator #(.DELAY_CYCLES(16), .NUM_INPUTS_PER_PATH(32)) dut16 (
    .CLK(CLK), .RST(RST),
`ifdef PREDELAY_DRAIN_EN
    .drain(drain),
`endif
    .in_valid(in_valid),
    .bf_out0_re(bf_out0_re), .bf_out0_im(bf_out0_im),
    .bf_out1_re(bf_out1_re), .bf_out1_im(bf_out1_im),
    .cm_out0_re(c0re16), .cm_out0_im(c0im16),
    .cm_out1_re(c1re16), .cm_out1_im(c1im16),
    .out_valid(ov16), .cntr_IFFT_input_pairs(cn16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input logic v, input logic dr,
                       input logic [31:0] d0, input logic [31:0] d1);
    for (int i = 0; i < 2; i++) begin
      int          dd;
      int          k;
      int          j;
      logic [31:0] a;
      logic [31:0] del;
      logic        crossed;
      dd = (i == 0) ? 4 : 16;
      if (rst) begin
        cnt[i] = 0; e0[i] = 32'h0; e1[i] = 32'h0; ec[i] = 5'd0; ev[i] = 1'b0;
      end else if (v || (DRAIN && dr && cnt[i] >= dd)) begin
        a = v ? d0 : 32'h0;
        k = cnt[i];
        hist[i][k] = v ? d1 : 32'h0;
        cnt[i]++;
        if (k >= dd) begin
          j       = k - dd;
          del     = hist[i][j];
          crossed = ((j / dd) % 2) == 1;
          e0[i]   = crossed ? del : a;
          e1[i]   = crossed ? a : del;
          ec[i]   = 5'(j % 32);
          ev[i]   = 1'b1;
        end else begin
          ev[i] = 1'b0;
        end
      end else begin
        ev[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("d4_valid", {31'd0, ov4}, {31'd0, ev[0]});
    chk("d4_out0", {c0re4, c0im4}, e0[0]);
    chk("d4_out1", {c1re4, c1im4}, e1[0]);
    chk("d4_cntr", {27'd0, cn4}, {27'd0, ec[0]});
    chk("d16_valid", {31'd0, ov16}, {31'd0, ev[1]});
    chk("d16_out0", {c0re16, c0im16}, e0[1]);
    chk("d16_out1", {c1re16, c1im16}, e1[1]);
    chk("d16_cntr", {27'd0, cn16}, {27'd0, ec[1]});
  endtask

  task automatic step(input logic rst, input logic v, input logic dr,
                      input logic [31:0] d0, input logic [31:0] d1);
    RST = rst; in_valid = v; drain = dr;
    {bf_out0_re, bf_out0_im} = d0;
    {bf_out1_re, bf_out1_im} = d1;
    @(posedge CLK);
    #1;
    model(rst, v, dr, d0, d1);
    check_all();
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    // Reset for two cycles, then idle
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h9abc_def0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Prime + straight, then cross: re parts follow the directed pattern
    for (int k = 0; k < 13; k++) begin
      r0 = {16'(10 + k), 16'($urandom)};
      r1 = {16'(100 + k), 16'($urandom)};
      step(1'b0, 1'b1, 1'b0, r0, r1);
      if (k == 7) begin
        chk("spot_k7_out0re", {16'd0, c0re4}, 32'd17);
        chk("spot_k7_out1re", {16'd0, c1re4}, 32'd103);
        chk("spot_k7_cntr", {27'd0, cn4}, 32'd3);
      end
      if (k == 11) begin
        chk("spot_k11_out0re", {16'd0, c0re4}, 32'd107);
        chk("spot_k11_out1re", {16'd0, c1re4}, 32'd21);
        chk("spot_k11_cntr", {27'd0, cn4}, 32'd7);
      end
      if (k == 12) begin
        chk("spot_k12_out0re", {16'd0, c0re4}, 32'd22);
        chk("spot_k12_out1re", {16'd0, c1re4}, 32'd108);
      end
    end

    // Three-cycle stall, then resume
    for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    step(1'b0, 1'b1, 1'b0, $urandom, $urandom);

    // Randomized run: covers pair-counter wrap and switch toggles on D=16
    for (int s = 0; s < 160; s++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Reset mid-run while in_valid is high, then re-prime
    for (int s = 0; s < 6; s++) step(1'b0, 1'b1, 1'b0, $urandom, $urandom);
    step(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b1, 1'b0, $urandom, $urandom);
      chk("reprime_no_out", {31'd0, ov4}, 32'd0);
    end
    for (int s = 0; s < 6; s++) step(1'b0, 1'b1, 1'b0, $urandom, $urandom);

    // Drain request after the last input (a plain stall without the feature)
    for (int s = 0; s < 5; s++) step(1'b0, 1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
